mem_port_arbiter: RTL

- Shares one single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage, lw/sw).
- Serialises requests and sequences each fixed-latency memory access with a small FSM.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Produces per-requester stall signals that the pipeline hazard logic uses to freeze stages.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/mem_arb_select.sv | 22 ++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mips_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Winner select: data first, unless a pending fetch has been starved to the limit.
module mem_arb_select
  import mips_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic             if_req,
  input  logic             dm_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             any_req_c,
  output owner_t           winner_c
);

  always_comb begin
    any_req_c = if_req | dm_req;
    winner_c  = OWN_IF;
    if (dm_req && !(if_req && (starve_cnt >= CNT_W'(STARVE_LIMIT)))) begin
      winner_c = OWN_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/MEM single-port memory arbiter with fixed-latency access sequencing.
// Optional stall counters under MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       dm_stall_cnt
`endif
);

  arb_state_t       state, state_nxt;
  owner_t           owner_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] starve_q;
  logic             any_req_c;
  owner_t           winner_c;
  logic             issue_c;
  logic             last_c;

  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .starve_cnt (starve_q),
    .any_req_c  (any_req_c),
    .winner_c   (winner_c)
  );

  // Next state and the combinational issue strobe; issue is blocked during reset.
  always_comb begin
    state_nxt = state;
    issue_c   = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req_c && !rst) begin
          issue_c   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory command is driven only on the issue cycle, zero otherwise.
  always_comb begin
    mem_en    = issue_c;
    mem_we    = issue_c && (winner_c == OWN_DM) && dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue_c) begin
      mem_addr = (winner_c == OWN_DM) ? dm_addr : if_addr;
    end
    if (mem_we) begin
      mem_wdata = dm_wdata;
    end
  end

  assign if_stall = if_req & ~if_ready;
  assign dm_stall = dm_req & ~dm_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner_q  <= OWN_IF;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      starve_q <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if (issue_c) begin
        owner_q <= winner_c;
        we_q    <= (winner_c == OWN_DM) && dm_we;
        cnt_q   <= CNT_W'(MEM_LAT - 1);
        // Count data wins that bypass a waiting fetch; any other outcome resets it.
        if ((winner_c == OWN_DM) && if_req) begin
          if (starve_q < CNT_W'(STARVE_LIMIT)) begin
            starve_q <= starve_q + CNT_W'(1);
          end
        end else begin
          starve_q <= '0;
        end
      end else if ((state == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (last_c) begin
        if (owner_q == OWN_IF) begin
          if_rdata <= mem_rdata;
          if_ready <= 1'b1;
        end else begin
          if (!we_q) begin
            dm_rdata <= mem_rdata;
          end
          dm_ready <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  // Saturating per-requester stall cycle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_stall_cnt <= '0;
      dm_stall_cnt <= '0;
    end else begin
      if (if_stall && (if_stall_cnt != 32'hFFFF_FFFF)) begin
        if_stall_cnt <= if_stall_cnt + 32'd1;
      end
      if (dm_stall && (dm_stall_cnt != 32'hFFFF_FFFF)) begin
        dm_stall_cnt <= dm_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
